// File: rtl/tile_ocl_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tile_ocl_dispatch
// Description : Per-tile OCL register dispatcher. Terminates one tile's slice
//               of the OCL control bus and forwards each single-beat access to
//               one of N_UNITS in-tile units selected by addr[15:8]. Unmapped
//               IDs and unresponsive units complete with a default response so
//               the host never hangs.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_ocl_dispatch #(
  parameter int          N_UNITS       = 8,
  parameter int          TIMEOUT       = 64,
  parameter logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ocl_awvalid,
  output logic                   ocl_awready,
  input  logic [31:0]            ocl_awaddr,
  input  logic                   ocl_wvalid,
  output logic                   ocl_wready,
  input  logic [31:0]            ocl_wdata,
  output logic                   ocl_bvalid,
  input  logic                   ocl_bready,
  input  logic                   ocl_arvalid,
  output logic                   ocl_arready,
  input  logic [31:0]            ocl_araddr,
  output logic                   ocl_rvalid,
  input  logic                   ocl_rready,
  output logic [31:0]            ocl_rdata,
  output logic [N_UNITS-1:0]     unit_wvalid,
  input  logic [N_UNITS-1:0]     unit_wready,
  output logic [7:0]             unit_addr,
  output logic [31:0]            unit_wdata,
  output logic [N_UNITS-1:0]     unit_rreq,
  input  logic [N_UNITS-1:0]     unit_rvalid,
  input  logic [32*N_UNITS-1:0]  unit_rdata,
  output logic [15:0]            timeout_count
);

  localparam int IDW  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int CNTW = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_W = 3'd1;
  localparam logic [2:0] S_W_FWD  = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_R_REQ  = 3'd4;
  localparam logic [2:0] S_R_WAIT = 3'd5;
  localparam logic [2:0] S_SEND_R = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [15:0]     tocnt_q, tocnt_d;

  logic               w_mapped;
  logic [IDW-1:0]     w_sel;
  logic [N_UNITS-1:0] w_onehot;
  logic               w_sel_wready;
  logic               w_sel_rvalid;
  logic [31:0]        w_sel_rdata;
  logic               w_expired;
  logic               w_unused;

  // Only the low 16 address bits carry unit ID and register offset.
  assign w_unused = &{1'b0, ocl_awaddr[31:16], ocl_araddr[31:16]};

  // Unit selection from the latched address; w_onehot is empty for unmapped IDs
  // so no strobe or request can ever leave for a non-existent unit.
  assign w_mapped     = ({24'd0, addr_q[15:8]} < N_UNITS);
  assign w_sel        = addr_q[8 +: IDW];
  assign w_onehot     = w_mapped ? (N_UNITS'(1) << w_sel) : '0;
  assign w_sel_wready = unit_wready[w_sel];
  assign w_sel_rvalid = unit_rvalid[w_sel];
  assign w_sel_rdata  = unit_rdata[32*w_sel +: 32];

  // Transaction sequencing: one access in flight, response wins over timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    tocnt_d   = tocnt_q;
    w_expired = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ocl_awvalid) begin
          addr_d  = ocl_awaddr[15:0];
          state_d = S_WAIT_W;
        end else if (ocl_arvalid) begin
          addr_d  = ocl_araddr[15:0];
          state_d = S_R_REQ;
        end
      end
      S_WAIT_W: begin
        if (ocl_wvalid) begin
          if (w_mapped) begin
            wdata_d = ocl_wdata;
            cnt_d   = '0;
            state_d = S_W_FWD;
          end else begin
            state_d = S_SEND_B;
          end
        end
      end
      S_W_FWD: begin
        if (w_sel_wready) begin
          state_d = S_SEND_B;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_SEND_B;
          w_expired = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND_B: begin
        if (ocl_bready) state_d = S_IDLE;
      end
      S_R_REQ: begin
        if (w_mapped) begin
          cnt_d   = '0;
          state_d = S_R_WAIT;
        end else begin
          rdata_d = DEFAULT_RDATA;
          state_d = S_SEND_R;
        end
      end
      S_R_WAIT: begin
        if (w_sel_rvalid) begin
          rdata_d = w_sel_rdata;
          state_d = S_SEND_R;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = DEFAULT_RDATA;
          state_d   = S_SEND_R;
          w_expired = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND_R: begin
        if (ocl_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_expired && (tocnt_q != 16'hFFFF)) tocnt_d = tocnt_q + 16'd1;
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tocnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tocnt_q <= tocnt_d;
    end
  end

  // Handshake outputs decode the state; IDLE readies are masked while in reset.
  assign ocl_awready   = (state_q == S_IDLE) & ~rst;
  assign ocl_arready   = (state_q == S_IDLE) & ~ocl_awvalid & ~rst;
  assign ocl_wready    = (state_q == S_WAIT_W);
  assign ocl_bvalid    = (state_q == S_SEND_B);
  assign ocl_rvalid    = (state_q == S_SEND_R);
  assign ocl_rdata     = rdata_q;
  assign unit_wvalid   = (state_q == S_W_FWD) ? w_onehot : '0;
  assign unit_rreq     = (state_q == S_R_REQ) ? w_onehot : '0;
  assign unit_addr     = addr_q[7:0];
  assign unit_wdata    = wdata_q;
  assign timeout_count = tocnt_q;

endmodule
`default_nettype wire

// File: doc/tile_ocl_dispatch.md
Name: tile_ocl_dispatch

Overview:
Per-tile OCL register dispatcher. It terminates one tile's slice of the OCL control bus, driven by the top-level OCL router, and forwards each single-beat register access to one of N_UNITS in-tile units, selected by address bits [15:8]. One transaction is in flight at a time. Unmapped unit IDs and unresponsive units complete with a default read value, so host software never hangs.

Parameters:
N_UNITS, 8, number of in-tile register units; unit ID = addr[15:8], valid IDs 0..N_UNITS-1
TIMEOUT, 64, cycles to wait for a unit response before forced completion (>=2)
DEFAULT_RDATA, 32'hDEADBEEF, read data returned for unmapped or timed-out reads

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ocl_awvalid  in  1  write address valid
ocl_awready  out  1  write address ready
ocl_awaddr  in  32  write address
ocl_wvalid  in  1  write data valid
ocl_wready  out  1  write data ready
ocl_wdata  in  32  write data
ocl_bvalid  out  1  write response valid
ocl_bready  in  1  write response ready
ocl_arvalid  in  1  read address valid
ocl_arready  out  1  read address ready
ocl_araddr  in  32  read address
ocl_rvalid  out  1  read data valid
ocl_rready  in  1  read data ready
ocl_rdata  out  32  read data
unit_wvalid  out  N_UNITS  one-hot write strobe to the selected unit
unit_wready  in  N_UNITS  per-unit write accept
unit_addr  out  8  register offset, addr[7:0] of the current transaction
unit_wdata  out  32  write data
unit_rreq  out  N_UNITS  one-hot, single-cycle read request pulse
unit_rvalid  in  N_UNITS  per-unit read data valid
unit_rdata  in  32*N_UNITS  per-unit read data; unit i occupies bits [32i+31:32i]
timeout_count  out  16  saturating count of timed-out transactions

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All valid, ready and strobe outputs are 0; ocl_rdata=0; unit_addr=0; unit_wdata=0; timeout_count=0.
  - A transaction in progress is abandoned; no response is issued.
- States: IDLE, WAIT_W, W_FWD, SEND_B, R_REQ, R_WAIT, SEND_R.
- IDLE:
  - ocl_awready=1. ocl_arready=!ocl_awvalid, so a write wins when both valids are high.
  - On the aw handshake: latch awaddr and go to WAIT_W.
  - On the ar handshake: latch araddr and go to R_REQ.
- Latched address: unit ID = addr[15:8]. The ID is mapped iff it is less than N_UNITS. unit_addr = addr[7:0].
- WAIT_W:
  - ocl_wready=1.
  - On ocl_wvalid: latch wdata and go to W_FWD.
  - If the ID is unmapped, go straight to SEND_B instead; the write is dropped silently.
- W_FWD:
  - unit_wvalid[id]=1 and held until unit_wready[id]. Then go to SEND_B.
  - Timeout counter starts at 0 on entry and increments each cycle without ready.
  - When it reaches TIMEOUT-1 without ready: go to SEND_B and increment timeout_count.
- SEND_B: ocl_bvalid=1 until ocl_bready, then return to IDLE.
- R_REQ:
  - Lasts exactly one cycle.
  - Mapped ID: unit_rreq[id]=1 for that cycle, then go to R_WAIT.
  - Unmapped ID: ocl_rdata<=DEFAULT_RDATA and go to SEND_R. No pulse is issued.
- R_WAIT:
  - On unit_rvalid[id]: ocl_rdata<=unit_rdata[id], go to SEND_R.
  - On timeout (same counter rule as W_FWD): ocl_rdata<=DEFAULT_RDATA, go to SEND_R, increment timeout_count.
  - unit_rvalid bits of non-selected units are ignored.
- SEND_R: ocl_rvalid=1, with ocl_rdata stable, until ocl_rready; then return to IDLE.
- Simultaneous ready/valid and timeout expiry in the same cycle: ready/valid wins. Data is used and timeout_count is unchanged.
- timeout_count saturates at 16'hFFFF.
- Minimum latency, no stalls:
  - Write: aw handshake cycle 0, w handshake cycle 1, unit_wvalid cycle 2, bvalid cycle 3.
  - Read: ar handshake cycle 0, rreq cycle 1, rvalid from unit cycle 2 at earliest, ocl_rvalid cycle 3.
- Upstream valids arriving outside their accepting state are held by the master and never dropped.

Test Plan:
- Write awaddr=0x0000_0310, wdata=0xA5A5_0001, unit 3 wready tied 1 -> unit_wvalid=8'b0000_1000 with unit_addr=0x10 and unit_wdata=0xA5A5_0001 for 1 cycle; ocl_bvalid 3 cycles after aw handshake.
- Read araddr=0x0000_0504, unit 5 returns rvalid with 0x1234_5678 two cycles after rreq -> single unit_rreq[5] pulse; ocl_rdata=0x1234_5678; rvalid held 4 cycles while rready=0.
- Read araddr=0x0000_0900 with N_UNITS=8 -> no unit_rreq; ocl_rdata=0xDEADBEEF; timeout_count unchanged. Write to unit 9 -> no unit_wvalid; bvalid still issued.
- Read unit 2 that never responds, TIMEOUT=64 -> ocl_rdata=0xDEADBEEF after 64 R_WAIT cycles; timeout_count=1. Repeat with unit_rvalid in the expiry cycle -> unit data returned, timeout_count stays 1.
- awvalid and arvalid asserted together -> write completes first (bvalid), then the read is accepted; no interleaving.
- rst pulsed while in W_FWD -> outputs zero immediately; no bvalid; next transaction completes normally.
